// File: rtl/mbinit_repair_seq.sv
// MBINIT repair step sequencer: init/result/done sideband exchanges with the partner,
// result checking against the expected track mask, bounded retries and response timeouts.
`timescale 1ns/1ps
module mbinit_repair_seq #(
    parameter int          RESULT_W       = 3,
    parameter int          MAX_RETRY      = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd8000
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                i_enable,
    input  logic                i_track_done,
    input  logic [3:0]          i_Rx_SbMessage,
    input  logic                i_msg_valid,
    input  logic                i_Busy_SideBand,
    input  logic                i_falling_edge_busy,
    input  logic                i_ValidOutDatat_ModulePartner,
    input  logic [RESULT_W-1:0] i_result_logged,
    input  logic [RESULT_W-1:0] i_expected_mask,
    output logic [3:0]          o_TX_SbMessage,
    output logic                o_ValidOutDatat_Module,
    output logic                o_Pattern_En,
    output logic                o_Module_end,
    output logic                o_train_error_req,
    output logic                o_timeout,
    output logic [2:0]          o_retry_count
);
    localparam logic [3:0] MSG_INIT_REQ    = 4'd1;
    localparam logic [3:0] MSG_INIT_RESP   = 4'd2;
    localparam logic [3:0] MSG_RESULT_REQ  = 4'd3;
    localparam logic [3:0] MSG_RESULT_RESP = 4'd4;
    localparam logic [3:0] MSG_DONE_REQ    = 4'd5;
    localparam logic [3:0] MSG_DONE_RESP   = 4'd6;
    localparam logic [2:0] MAX_RETRY_C     = 3'(MAX_RETRY);

    typedef enum logic [3:0] {
        IDLE,
        INIT_REQ,
        WAIT_RESP,
        PATTERN,
        CHK_BUSY_RES,
        RESULT_REQ,
        CHECK_RESULT,
        CHK_BUSY_DONE,
        DONE_REQ,
        DONE,
        ERROR
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] timer_reg;
    logic [15:0] timer_next;
    logic [2:0]  retry_next;
    logic        timeout_next;
    logic [3:0]  tx_msg_next;
    logic        sb_free;
    logic        timer_expired;
    logic        result_pass;

    always_comb begin
        sb_free       = ~i_Busy_SideBand & ~i_ValidOutDatat_ModulePartner;
        timer_expired = (timer_reg + 16'd1) == TIMEOUT_CYCLES;
        result_pass   = (i_result_logged & i_expected_mask) == i_expected_mask;
        state_next    = state_reg;
        retry_next    = o_retry_count;
        timeout_next  = o_timeout;

        if (!i_enable) begin
            state_next   = IDLE;
            retry_next   = 3'd0;
            timeout_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sb_free) state_next = INIT_REQ;
                end
                INIT_REQ, RESULT_REQ, DONE_REQ: begin
                    if (i_falling_edge_busy) state_next = WAIT_RESP;
                end
                WAIT_RESP: begin
                    // A valid response wins over a timeout landing in the same cycle.
                    if (i_msg_valid && i_Rx_SbMessage == MSG_INIT_RESP) begin
                        state_next = PATTERN;
                    end else if (i_msg_valid && i_Rx_SbMessage == MSG_RESULT_RESP) begin
                        state_next = CHECK_RESULT;
                    end else if (i_msg_valid && i_Rx_SbMessage == MSG_DONE_RESP) begin
                        state_next = DONE;
                    end else if (timer_expired) begin
                        state_next   = ERROR;
                        timeout_next = 1'b1;
                    end
                end
                PATTERN: begin
                    if (i_track_done) begin
                        state_next = CHK_BUSY_RES;
                    end else if (timer_expired) begin
                        state_next   = ERROR;
                        timeout_next = 1'b1;
                    end
                end
                CHK_BUSY_RES: begin
                    if (sb_free) state_next = RESULT_REQ;
                end
                CHECK_RESULT: begin
                    // A retry re-arms through IDLE but keeps the retry count.
                    if (result_pass) begin
                        state_next = CHK_BUSY_DONE;
                    end else if (o_retry_count < MAX_RETRY_C) begin
                        state_next = IDLE;
                        retry_next = o_retry_count + 3'd1;
                    end else begin
                        state_next = ERROR;
                    end
                end
                CHK_BUSY_DONE: begin
                    if (sb_free) state_next = DONE_REQ;
                end
                DONE, ERROR: begin
                    state_next = state_reg;
                end
                default: begin
                    state_next   = IDLE;
                    retry_next   = 3'd0;
                    timeout_next = 1'b0;
                end
            endcase
        end

        if ((state_reg == WAIT_RESP || state_reg == PATTERN) && state_next == state_reg) begin
            timer_next = timer_reg + 16'd1;
        end else begin
            timer_next = 16'd0;
        end

        case (state_next)
            INIT_REQ:   tx_msg_next = MSG_INIT_REQ;
            RESULT_REQ: tx_msg_next = MSG_RESULT_REQ;
            DONE_REQ:   tx_msg_next = MSG_DONE_REQ;
            default:    tx_msg_next = 4'h0;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg              <= IDLE;
            timer_reg              <= 16'd0;
            o_retry_count          <= 3'd0;
            o_timeout              <= 1'b0;
            o_TX_SbMessage         <= 4'h0;
            o_ValidOutDatat_Module <= 1'b0;
            o_Pattern_En           <= 1'b0;
            o_Module_end           <= 1'b0;
            o_train_error_req      <= 1'b0;
        end else begin
            state_reg              <= state_next;
            timer_reg              <= timer_next;
            o_retry_count          <= retry_next;
            o_timeout              <= timeout_next;
            o_TX_SbMessage         <= tx_msg_next;
            o_ValidOutDatat_Module <= (state_next == INIT_REQ) || (state_next == RESULT_REQ) ||
                                      (state_next == DONE_REQ);
            o_Pattern_En           <= (state_next == PATTERN);
            o_Module_end           <= (state_next == DONE);
            o_train_error_req      <= (state_next == ERROR);
        end
    end
endmodule
